// File: rtl/mult_share_ctrl_pkg.sv
// mult_share_ctrl_pkg: FSM state encoding and requester ID constants shared by the multiplier arbiter.
package mult_share_ctrl_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/mult_share_ctrl_core.sv
// mult_core: registered unsigned times-table multiplier; product loads on en, holds otherwise, clears on rst.
module mult_core #(
  parameter int OPW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [2*OPW-1:0] product
);
  localparam int PW = 2 * OPW;
  logic [PW-1:0] w_a;
  logic [PW-1:0] w_b;
  assign w_a = PW'(a);
  assign w_b = PW'(b);
  always_ff @(posedge clk) begin
    if (rst) product <= '0;
    else if (en) product <= w_a * w_b;
  end
endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin share of one registered multiplier between two valid/ready requesters,
// returning the product tagged with the requester ID on a single valid/ready response channel.
module mult_share_ctrl
  import mult_share_ctrl_pkg::*;
#(
  parameter int OPW   = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [OPW-1:0]   req0_a,
  input  logic [OPW-1:0]   req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [OPW-1:0]   req1_a,
  input  logic [OPW-1:0]   req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [2*OPW-1:0] rsp_result,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             r_last_grant;
  logic             r_id;
  logic [OPW-1:0]   r_a;
  logic [OPW-1:0]   r_b;
  logic [CNT_W-1:0] r_count;
  logic             w_g0;
  logic             w_g1;
  logic             w_hs;
  logic             w_rsp_hs;
  logic             w_mul_en;
  // On contention the port that did not win last time is granted.
  always_comb begin
    w_g0 = req0_valid & (~req1_valid | (r_last_grant == PORT1));
    w_g1 = req1_valid & (~req0_valid | (r_last_grant == PORT0));
    req0_ready = (r_state == ST_IDLE) & w_g0;
    req1_ready = (r_state == ST_IDLE) & w_g1;
    w_hs = req0_ready | req1_ready;
    w_rsp_hs = rsp_valid & rsp_ready;
    w_next = (r_state == ST_IDLE) ? (w_hs ? ST_MUL : ST_IDLE) :
             (r_state == ST_MUL)  ? ST_RESP :
             (r_state == ST_RESP && !w_rsp_hs) ? ST_RESP : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= PORT1;
      r_id         <= PORT0;
      r_a          <= '0;
      r_b          <= '0;
      r_count      <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_a          <= req1_ready ? req1_a : req0_a;
        r_b          <= req1_ready ? req1_b : req0_b;
        r_id         <= req1_ready ? PORT1 : PORT0;
        r_last_grant <= req1_ready ? PORT1 : PORT0;
      end
      if (w_rsp_hs) r_count <= r_count + CNT_W'(1);
    end
  end
  assign w_mul_en  = (r_state == ST_MUL);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_id;
  assign busy      = (r_state != ST_IDLE);
  assign op_count  = r_count;
  mult_core #(.OPW(OPW)) u_core (
    .clk     (clk),
    .rst     (rst),
    .en      (w_mul_en),
    .a       (r_a),
    .b       (r_b),
    .product (rsp_result)
  );
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed vectors with hand-computed expectations for the shared multiplier controller.
module tb_mult_share_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_id, rsp_ready, busy;
  logic [5:0] rsp_result;
  logic [7:0] op_count;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mult_share_ctrl #(.OPW(3), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .op_count   (op_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    step(); step();
    check("rst_r0", req0_ready, 0);
    check("rst_r1", req1_ready, 0);
    check("rst_rv", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_res", rsp_result, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", op_count, 0);
    rst = 1'b0;
    step();
    // single request: p0 3*5
    req0_valid = 1; req0_a = 3; req0_b = 5;
    #1;
    check("s_r0", req0_ready, 1);
    check("s_r1", req1_ready, 0);
    step();
    req0_valid = 0;
    #1;
    check("s_busy", busy, 1);
    check("s_rv_mul", rsp_valid, 0);
    check("s_r0_mul", req0_ready, 0);
    step();
    check("s_rv", rsp_valid, 1);
    check("s_id", rsp_id, 0);
    check("s_res", rsp_result, 15);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check("s_cnt", op_count, 1);
    check("s_rv_idle", rsp_valid, 0);
    check("s_res_hold", rsp_result, 15);
    // contention from reset
    rst = 1; step(); rst = 0;
    check("c_cnt0", op_count, 0);
    req0_valid = 1; req0_a = 2; req0_b = 7;
    req1_valid = 1; req1_a = 6; req1_b = 6;
    rsp_ready = 1;
    #1;
    check("c1_r0", req0_ready, 1);
    check("c1_r1", req1_ready, 0);
    step(); step();
    check("c1_id", rsp_id, 0);
    check("c1_res", rsp_result, 14);
    step();
    check("c2_r0", req0_ready, 0);
    check("c2_r1", req1_ready, 1);
    step(); step();
    check("c2_id", rsp_id, 1);
    check("c2_res", rsp_result, 36);
    req0_a = 3; req0_b = 3; req1_a = 2; req1_b = 5;
    step();
    #1;
    check("c3_r0", req0_ready, 1);
    check("c3_r1", req1_ready, 0);
    step(); step();
    check("c3_id", rsp_id, 0);
    check("c3_res", rsp_result, 9);
    step();
    check("c4_r1", req1_ready, 1);
    step(); step();
    check("c4_id", rsp_id, 1);
    check("c4_res", rsp_result, 10);
    step();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    check("c_cnt", op_count, 4);
    // backpressure: p1 7*7, consumer stalls 5 cycles while p0 waits
    req1_valid = 1; req1_a = 7; req1_b = 7;
    #1;
    check("b_r1", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    req0_valid = 1; req0_a = 1; req0_b = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("b_rv", rsp_valid, 1);
      check("b_id", rsp_id, 1);
      check("b_res", rsp_result, 49);
      check("b_r0", req0_ready, 0);
      check("b_cnt", op_count, 4);
      step();
    end
    rsp_ready = 1;
    step();
    req0_valid = 0; rsp_ready = 0;
    check("b_cnt_rel", op_count, 5);
    check("b_rv_rel", rsp_valid, 0);
    // zero operand
    req0_valid = 1; req0_a = 0; req0_b = 6;
    step();
    req0_valid = 0;
    step();
    check("z_res", rsp_result, 0);
    check("z_id", rsp_id, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check("z_cnt", op_count, 6);
    // counter wrap after 256 completions
    rst = 1; step(); rst = 0;
    req0_valid = 1; req0_a = 1; req0_b = 1; rsp_ready = 1;
    repeat (255 * 3) step();
    check("w_cnt255", op_count, 255);
    repeat (3) step();
    check("w_cnt0", op_count, 0);
    req0_valid = 0; rsp_ready = 0;
    #1;
    check("w_busy", busy, 0);
    // reset during MUL discards the op
    req0_valid = 1; req0_a = 4; req0_b = 4;
    step();
    req0_valid = 0;
    check("m_busy", busy, 1);
    rst = 1;
    step();
    rst = 0;
    check("m_busy_rst", busy, 0);
    check("m_rv_rst", rsp_valid, 0);
    check("m_res_rst", rsp_result, 0);
    check("m_cnt_rst", op_count, 0);
    step();
    check("m_rv_after", rsp_valid, 0);
    req0_valid = 1; req1_valid = 1; req1_a = 1; req1_b = 3;
    #1;
    check("m_lg_r0", req0_ready, 1);
    req0_valid = 0;
    #1;
    check("m_r1", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    check("m_rv", rsp_valid, 1);
    check("m_id", rsp_id, 1);
    check("m_res", rsp_result, 3);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check("m_cnt", op_count, 1);
    // idle hold
    for (int i = 0; i < 10; i++) begin
      step();
      check("i_busy", busy, 0);
      check("i_rv", rsp_valid, 0);
      check("i_res", rsp_result, 3);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Shares one registered times-table multiplier between two requesters (port 0, port 1).
- Round-robin arbitration over valid/ready request handshakes.
- Sequences the multiplier enable, captures the product and returns it with the requester ID on a single valid/ready response channel.
- Sits between the requesting blocks and the multiplier datapath; the multiplier core is instantiated inside.

Parameters:
- OPW, 3, operand width in bits; product width is 2*OPW.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 has an operand pair.
- req0_a  in  OPW  port 0 operand a.
- req0_b  in  OPW  port 0 operand b.
- req0_ready  out  1  port 0 request accepted this cycle.
- req1_valid / req1_a / req1_b / req1_ready: as port 0, for port 1.
- rsp_valid  out  1  product available.
- rsp_id  out  1  requester of the current product (0 or 1).
- rsp_result  out  2*OPW  product a*b, unsigned, full width (7*7=49 fits in 6 bits).
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  number of completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state=IDLE, req0_ready=0, req1_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, op_count=0, last_grant=1 (port 0 wins the first contest). Multiplier core output is cleared.
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - grant = the only valid port; if both are valid, the port != last_grant.
  - reqN_ready = (state==IDLE) & grant[N]. It is combinational and depends on valid. At most one ready is high.
  - On handshake: latch a, b and id; set last_grant=id; go to MUL.
  - With no valid input, stay in IDLE.
- MUL:
  - mult_en=1 for exactly one cycle; the core registers a*b at the end of this cycle.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_result stay stable until rsp_valid & rsp_ready.
  - On that handshake: op_count+1 (wrap at max), go to IDLE.
  - If rsp_ready is low, hold indefinitely; no new request is accepted.
- Latency: request handshake in cycle N gives rsp_valid high in cycle N+2.
- Throughput: at most one operation per 3 cycles.
- A requester must hold valid/a/b stable until ready; a requester that drops valid before being granted loses nothing.
- Operands 0 give result 0. Maximum operands (2^OPW-1)^2 produce no truncation.
- Simultaneous events:
  - Both ports valid every cycle: grants strictly alternate.
  - A request arriving while the block is busy waits.
- rst mid-operation (MUL or RESP): in-flight op discarded, no response, all outputs return to reset values on the next edge.
- Outside RESP: rsp_result keeps its last value and rsp_valid=0.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, MUL=1, RESP=2, 2 bits) and the ID constants PORT0=0, PORT1=1.
- One sub-module, mult_core: clk, rst, en, a, b, product.
  - product <= a*b when en, held otherwise, cleared on rst.
  - It has the same contract as the existing times-table multiplier, so that core can be substituted.

Test Plan:
- Single request: port 0 a=3 b=5 in cycle N -> req0_ready=1 in N; rsp_valid=1, rsp_id=0, rsp_result=15 in N+2; op_count=1 after rsp_ready.
- Contention: both valid from reset, p0 (2,7), p1 (6,6), rsp_ready=1 -> responses in order id0=14 then id1=36; the next pair is granted p0 then p1, alternating.
- Backpressure: p1 (7,7), rsp_ready held low 5 cycles -> rsp_valid held, result=49 stable, req ready low throughout; op_count increments once on release.
- Boundary: (0,6) -> 0; (7,7) -> 49. op_count preset by 256 completions wraps to 0.
- Reset mid-op: assert rst during MUL for p0 (4,4) -> no rsp_valid, busy=0 next cycle, last_grant=1; a subsequent p1 (1,3) returns 3 with id 1.
- Idle hold: no valid for 10 cycles -> busy=0, rsp_valid=0, rsp_result unchanged.
